// File: rtl/lsu_mem_port.sv
// ============================================================================
// lsu_mem_port : load/store port between execute and data memory; holds the
// raw word, offset and funct3 for the alignment stage. Option: MISALIGN_TRAP_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem_port #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_load,
  output logic [XLEN-1:0] out_rdata,
  output logic [1:0]      out_sft,
  output logic [2:0]      out_funct3,
  output logic            out_misalign
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]      sft;
  logic [3:0]      mask;
  logic [XLEN-1:0] wdata_rep;
  logic            misalign;
  logic            trap;
  logic            accept;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [3:0]      mask_q;
  logic [1:0]      sft_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic            misalign_q;

  assign sft = req_addr[1:0];

  // Width is selected by funct3[1:0]; bit 2 only distinguishes signed loads.
  always_comb begin
    mask      = 4'b1111;
    wdata_rep = req_wdata;
    misalign  = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin
        mask      = 4'b0001 << sft;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask      = 4'b0011 << sft;
        wdata_rep = {2{req_wdata[15:0]}};
        misalign  = (sft == 2'd3);
      end
      default: begin
        misalign  = (sft != 2'd0);
      end
    endcase
  end

  assign trap   = TRAP_EN & misalign;
  assign accept = (state == S_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = trap ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_nxt = is_load_q ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Loads carry a zero mask/data so the memory never sees a stray write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mask_q     <= '0;
      sft_q      <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= {req_addr[XLEN-1:2], 2'b00};
        wdata_q    <= req_we ? wdata_rep : '0;
        rdata_q    <= '0;
        mask_q     <= req_we ? mask : 4'b0000;
        sft_q      <= sft;
        funct3_q   <= req_funct3;
        is_load_q  <= !req_we;
        misalign_q <= trap;
      end
      if ((state == S_WAIT) && mem_rvalid) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr     = addr_q;
  assign mem_we       = mask_q;
  assign mem_wdata    = wdata_q;
  assign out_is_load  = is_load_q;
  assign out_rdata    = rdata_q;
  assign out_sft      = sft_q;
  assign out_funct3   = funct3_q;
  assign out_misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
// tb_lsu_mem_port : directed self-checking bench for lsu_mem_port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_req, mem_gnt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        mem_rvalid;
  logic        out_valid, out_ready, out_is_load, out_misalign;
  logic [31:0] out_rdata;
  logic [1:0]  out_sft;
  logic [2:0]  out_funct3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_load(out_is_load),
    .out_rdata(out_rdata), .out_sft(out_sft), .out_funct3(out_funct3),
    .out_misalign(out_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h5A5A5A5A; out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    req_valid = 1; req_we = 1; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'b010; mem_gnt = 1; mem_rvalid = 1; mem_rdata = $urandom;
    out_ready = 1;
    step(); step();
    checks++;
    if ({req_ready, mem_req, out_valid, mem_we, out_rdata} !== {3'b100, 4'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset got rdy/req/val/we/rdata=%b%b%b/%h/%h exp 100/0/0",
               req_ready, mem_req, out_valid, mem_we, out_rdata);
    end
    checks++;
    if ({out_is_load, out_misalign, mem_addr} !== 34'h0) begin
      failures++;
      $display("FAIL reset_misc got is_load=%b mis=%b addr=%h exp 0 0 0",
               out_is_load, out_misalign, mem_addr);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_load_lb();
    req_valid = 1; req_we = 0; req_addr = 32'h1003; req_funct3 = 3'b000;
    req_wdata = 32'hFFFFFFFF;
    step();                       // accept edge 0
    req_valid = 0;
    checks++;
    if ({mem_req, mem_addr, mem_we, out_valid, req_ready} !== {1'b1, 32'h1000, 4'h0, 2'b00}) begin
      failures++;
      $display("FAIL lb_req got req=%b addr=%h we=%h val=%b rdy=%b exp 1 1000 0 0 0",
               mem_req, mem_addr, mem_we, out_valid, req_ready);
    end
    mem_gnt = 1;
    step();                       // grant edge 1
    mem_gnt = 0;
    checks++;
    if ({mem_req, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL lb_wait got req=%b val=%b exp 0 0", mem_req, out_valid);
    end
    mem_rvalid = 1; mem_rdata = 32'h80AA55CC;
    step();                       // rvalid edge 2 -> out_valid in cycle 3
    mem_rvalid = 0; mem_rdata = 32'h0BADF00D;
    checks++;
    if ({out_valid, out_is_load, out_rdata, out_sft, out_funct3, out_misalign} !==
        {2'b11, 32'h80AA55CC, 2'd3, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL lb_resp got val=%b ld=%b rdata=%h sft=%0d f3=%0d mis=%b exp 1 1 80aa55cc 3 0 0",
               out_valid, out_is_load, out_rdata, out_sft, out_funct3, out_misalign);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if ({out_valid, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL lb_done got val=%b rdy=%b exp 0 1", out_valid, req_ready);
    end
  endtask

  task automatic test_store_sh();
    req_valid = 1; req_we = 1; req_addr = 32'h2002; req_funct3 = 3'b001;
    req_wdata = 32'h1234BEEF;
    step();
    req_valid = 0; req_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, mem_addr, mem_we, mem_wdata, out_valid} !==
          {1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF, 1'b0}) begin
        failures++;
        $display("FAIL sh_hold[%0d] got req=%b addr=%h we=%b wd=%h val=%b exp 1 2000 1100 beefbeef 0",
                 i, mem_req, mem_addr, mem_we, mem_wdata, out_valid);
      end
      if (i == 3) mem_gnt = 1;
      step();
    end
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;   // ignored outside WAIT
    step();
    mem_rvalid = 0;
    checks++;
    if ({out_valid, out_is_load, out_rdata, mem_req, out_sft, out_funct3} !==
        {2'b10, 32'h0, 1'b0, 2'd2, 3'b001}) begin
      failures++;
      $display("FAIL sh_resp got val=%b ld=%b rdata=%h req=%b sft=%0d f3=%0d exp 1 0 0 0 2 1",
               out_valid, out_is_load, out_rdata, mem_req, out_sft, out_funct3);
    end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_store_widths();
    logic [31:0] addrs [4] = '{32'h4001, 32'h4004, 32'h400B, 32'h4011};
    logic [31:0] wds   [4] = '{32'hAABBCCDD, 32'h01234567, 32'h00000011, 32'hFFFF9876};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b010, 3'b000, 3'b001};
    logic [31:0] e_addr[4] = '{32'h4000, 32'h4004, 32'h4008, 32'h4010};
    logic [3:0]  e_we  [4] = '{4'b0010, 4'b1111, 4'b1000, 4'b0110};
    logic [31:0] e_wd  [4] = '{32'hDDDDDDDD, 32'h01234567, 32'h11111111, 32'h98769876};
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_we = 1; req_addr = addrs[i]; req_wdata = wds[i];
      req_funct3 = f3s[i];
      step();
      req_valid = 0;
      checks++;
      if ({mem_req, mem_addr, mem_we, mem_wdata} !== {1'b1, e_addr[i], e_we[i], e_wd[i]}) begin
        failures++;
        $display("FAIL store[%0d] got req=%b addr=%h we=%b wd=%h exp 1 %h %b %h",
                 i, mem_req, mem_addr, mem_we, mem_wdata, e_addr[i], e_we[i], e_wd[i]);
      end
      mem_gnt = 1;
      step();                     // store: out_valid in cycle 2
      mem_gnt = 0;
      checks++;
      if ({out_valid, out_is_load, out_rdata} !== {2'b10, 32'h0}) begin
        failures++;
        $display("FAIL store_resp[%0d] got val=%b ld=%b rdata=%h exp 1 0 0",
                 i, out_valid, out_is_load, out_rdata);
      end
      out_ready = 1;
      step();
      out_ready = 0;
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1; req_we = 0; req_addr = 32'h0008; req_funct3 = 3'b010;
    step();
    req_valid = 0;
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid  = (i == 2);
      req_addr   = 32'h7777;
      mem_rvalid = (i == 3);
      mem_rdata  = 32'h12345678;
      checks++;
      if ({out_valid, req_ready, mem_req, out_is_load, out_rdata, out_sft, out_funct3} !==
          {4'b1001, 32'hDEADBEEF, 2'd0, 3'b010}) begin
        failures++;
        $display("FAIL bp[%0d] got val=%b rdy=%b req=%b ld=%b rdata=%h sft=%0d f3=%0d exp 1 0 0 1 deadbeef 0 2",
                 i, out_valid, req_ready, mem_req, out_is_load, out_rdata, out_sft, out_funct3);
      end
      step();
    end
    req_valid = 0; mem_rvalid = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if ({out_valid, req_ready, mem_req} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release got val=%b rdy=%b req=%b exp 0 1 0", out_valid, req_ready, mem_req);
    end
  endtask

  task automatic test_async_reset();
    // Reset while in REQ: mem_req must drop without a clock edge.
    req_valid = 1; req_we = 0; req_addr = 32'h6000; req_funct3 = 3'b010;
    step();
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({mem_req, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL arst_req got req=%b rdy=%b exp 0 1", mem_req, req_ready);
    end
    #1 rst_n = 1;
    step();
    // Reset while in WAIT, then a late rvalid must be discarded.
    req_valid = 1;
    step();
    req_valid = 0;
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({mem_req, out_valid, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL arst_wait got req=%b val=%b rdy=%b exp 0 0 1", mem_req, out_valid, req_ready);
    end
    #1 rst_n = 1;
    mem_rvalid = 1; mem_rdata = 32'hFEEDFACE;
    step();
    mem_rvalid = 0;
    step();
    checks++;
    if ({out_valid, out_rdata, req_ready} !== {1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL arst_late_rvalid got val=%b rdata=%h rdy=%b exp 0 0 1", out_valid, out_rdata, req_ready);
    end
  endtask

  task automatic test_misalign();
    req_valid = 1; req_we = 0; req_addr = 32'h3001; req_funct3 = 3'b010;
    step();
    req_valid = 0;
`ifdef MISALIGN_TRAP_EN
    checks++;
    if ({mem_req, out_valid, out_misalign, out_is_load, out_rdata, out_sft} !==
        {4'b0111, 32'h0, 2'd1}) begin
      failures++;
      $display("FAIL lw_trap got req=%b val=%b mis=%b ld=%b rdata=%h sft=%0d exp 0 1 1 1 0 1",
               mem_req, out_valid, out_misalign, out_is_load, out_rdata, out_sft);
    end
    out_ready = 1;
    step();
    out_ready = 0;
`else
    checks++;
    if ({mem_req, mem_addr, mem_we, out_misalign} !== {1'b1, 32'h3000, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL lw_mis_req got req=%b addr=%h we=%h mis=%b exp 1 3000 0 0",
               mem_req, mem_addr, mem_we, out_misalign);
    end
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h13572468;
    step();
    mem_rvalid = 0;
    checks++;
    if ({out_valid, out_misalign, out_rdata, out_sft} !== {2'b10, 32'h13572468, 2'd1}) begin
      failures++;
      $display("FAIL lw_mis_resp got val=%b mis=%b rdata=%h sft=%0d exp 1 0 13572468 1",
               out_valid, out_misalign, out_rdata, out_sft);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    // SH at offset 3 issues with the mask truncated to the top byte.
    req_valid = 1; req_we = 1; req_addr = 32'h5003; req_funct3 = 3'b001;
    req_wdata = 32'h0000CAFE;
    step();
    req_valid = 0;
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h5000, 4'b1000, 32'hCAFECAFE}) begin
      failures++;
      $display("FAIL sh_mis got req=%b addr=%h we=%b wd=%h exp 1 5000 1000 cafecafe",
               mem_req, mem_addr, mem_we, mem_wdata);
    end
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    out_ready = 1;
    step();
    out_ready = 0;
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_lb();
    test_store_sh();
    test_store_widths();
    test_backpressure();
    test_async_reset();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
